multicycle_control: RTL
=======================

# multicycle_control

Multi-cycle control FSM that sequences the 16-bit register block and ALU datapath (mary, shelley, comp, ra registers plus ALU). Each instruction runs as fetch, decode, then an execute or memory phase. The block owns all write enables, mux selects and ALU opcode for that datapath, plus a single memory request/ready handshake. It sits between the instruction register and the datapath; one instance per core.

## Interface
- No parameters.
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; forces state START
- opcode  in  4  instruction[15:12] from instruction register
- mem_ready  in  1  memory completes current request this cycle
- overflow  in  1  ALU signed overflow, combinational from datapath
- comp_zero  in  1  comp register == 0
- mem_req / mem_we  out  1 / 1  memory request; write when mem_we=1
- addr_sel  out  1  0 = pc, 1 = zero-extended immediate
- ir_write, pc_inc, pc_load  out  1 each  IR load, pc+2, pc<=immediate
- mary_write, shelley_write, comp_write, ra_write  out  1 each  register write enables
- mary_src, shelley_src  out  2 each  00 aluout, 01 memval, 10 immediate
- ra_src  out  1  0 pc, 1 aluout
- SrcA  out  1  0 mary, 1 pc
- SrcB  out  2  00 memval, 01 immediate, 10 const 2, 11 shelley
- AluOp  out  3  010 add, 110 sub
- trap  out  1  halted on illegal opcode or overflow
- state  out  3  current state, for debug

## Operation
- States: START=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, TRAP=7. Outputs are Moore-decoded from state, gated by mem_ready/overflow/comp_zero where stated; any output not listed for a state is 0.
- START: all outputs 0; next FETCH.
- FETCH: mem_req=1, addr_sel=0. Hold until mem_ready; in the ready cycle ir_write=1, pc_inc=1; next DECODE.
- DECODE: no side effects. Opcodes 0x0,0x2,0x5,0x6,0x7 go to EXEC; 0x1,0x3,0x4 go to MEM; 0x8–0xF go to TRAP.
- EXEC:
  - 0x0 ADDI: SrcA=0, SrcB=01, AluOp=010, mary_src=00, mary_write=1.
  - 0x2 SUBI: as ADDI with AluOp=110.
  - 0x5 COMP: SrcA=0, SrcB=11, AluOp=110, comp_write=1.
  - 0x6 JAL: ra_src=0, ra_write=1, pc_load=1.
  - 0x7 BEQ: pc_load=comp_zero.
  - Next FETCH.
- MEM: mem_req=1, addr_sel=1; hold until mem_ready. Writes fire only in the mem_ready cycle.
  - 0x1 ADDM: SrcA=0, SrcB=00, AluOp=010, mary_src=00, mary_write.
  - 0x3 LOAD: shelley_src=01, shelley_write.
  - 0x4 STORE: mem_we=1 for the whole MEM state; no register write.
  - Next FETCH.
- TRAP: trap=1, all other outputs 0. Stays in TRAP until reset.
- opcode is sampled only in DECODE and EXEC/MEM. IR is stable after the FETCH ready cycle.

## Timing
- Reset asserted: state=START immediately. All outputs 0, including trap. First FETCH begins one clock after reset deasserts.
- Zero-wait memory (mem_ready=1 on first request cycle):
  - ALU and jump instructions: 3 cycles (FETCH, DECODE, EXEC).
  - Memory instructions: 3 cycles (FETCH, DECODE, MEM).
- Each cycle mem_ready is low in FETCH or MEM adds one cycle. Outputs hold constant while waiting.
- mem_ready is ignored outside FETCH and MEM.
- Reset mid-instruction aborts with no further write enables. A write enable in the same cycle as reset assertion is not guaranteed to take effect.
- Register writes land on the clock edge ending EXEC or the MEM ready cycle.

## Configuration
- CTRL_OVF_TRAP_EN defined: in EXEC for ADDI/SUBI and in the MEM ready cycle for ADDM, overflow=1 forces mary_write=0 and next state TRAP.
- CTRL_OVF_TRAP_EN undefined: overflow is ignored, the write occurs, and trap asserts only for illegal opcodes.

## Test plan
- Reset, then opcode=0x0, mem_ready=1 -> state sequence 0,1,2,3,1. mary_write=1 only in state 3 with SrcB=01, AluOp=010. Datapath mary=420, imm=84 gives 504.
- opcode=0x3, mem_ready low 2 cycles in MEM -> MEM lasts 3 cycles. shelley_write=1 only in the third, with shelley_src=01. Total 5 cycles.
- opcode=0x7 with comp_zero=0, then 0x7 with comp_zero=1 -> pc_load 0, then 1, in EXEC only. No register writes.
- opcode=0xA -> DECODE then TRAP with trap=1 for 10+ cycles. Assert reset -> state=0, trap=0 asynchronously.
- With CTRL_OVF_TRAP_EN: ADDI with overflow=1 in EXEC -> mary_write=0, next state TRAP. Without the macro: mary_write=1, next state FETCH.
- opcode=0x4, assert reset in the second MEM wait cycle -> mem_we and mem_req drop to 0 immediately, state=START.

Source files
------------

// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle control FSM for the 16-bit register/ALU
// datapath. Each instruction runs FETCH, DECODE, then EXEC or MEM. All datapath
// controls are Moore-decoded from the state. Write enables are also gated by
// mem_ready, comp_zero or overflow where an instruction needs it.
// Optional feature: define CTRL_OVF_TRAP_EN to make a signed overflow on
// ADDI/SUBI/ADDM suppress the mary write and halt in TRAP.
module multicycle_control (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       mem_ready,
  input  logic       overflow,
  input  logic       comp_zero,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic       ir_write,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       mary_write,
  output logic       shelley_write,
  output logic       comp_write,
  output logic       ra_write,
  output logic [1:0] mary_src,
  output logic [1:0] shelley_src,
  output logic       ra_src,
  output logic       SrcA,
  output logic [1:0] SrcB,
  output logic [2:0] AluOp,
  output logic       trap,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    START  = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    TRAP   = 3'd7
  } state_t;

  localparam logic [3:0] OP_ADDI  = 4'h0;
  localparam logic [3:0] OP_ADDM  = 4'h1;
  localparam logic [3:0] OP_SUBI  = 4'h2;
  localparam logic [3:0] OP_LOAD  = 4'h3;
  localparam logic [3:0] OP_STORE = 4'h4;
  localparam logic [3:0] OP_COMP  = 4'h5;
  localparam logic [3:0] OP_JAL   = 4'h6;
  localparam logic [3:0] OP_BEQ   = 4'h7;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;

  localparam logic [1:0] SRC_ALUOUT = 2'b00;
  localparam logic [1:0] SRC_MEMVAL = 2'b01;
  localparam logic [1:0] SRCB_MEM   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_SHEL  = 2'b11;

`ifdef CTRL_OVF_TRAP_EN
  localparam logic OVF_TRAP = 1'b1;
`else
  localparam logic OVF_TRAP = 1'b0;
`endif

  state_t cur_state, nxt_state;
  logic   ovf_kill;

  // An overflow only matters when the trap feature is built in.
  assign ovf_kill = OVF_TRAP & overflow;
  assign state    = cur_state;

  // State register; reset returns to START immediately.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value; blocking here would create order races.
    if (reset) cur_state <= START;
    else       cur_state <= nxt_state;
  end

  // Next-state and Moore output decode with per-instruction gating.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a signal unassigned, which would infer a latch.
    nxt_state     = cur_state;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    addr_sel      = 1'b0;
    ir_write      = 1'b0;
    pc_inc        = 1'b0;
    pc_load       = 1'b0;
    mary_write    = 1'b0;
    shelley_write = 1'b0;
    comp_write    = 1'b0;
    ra_write      = 1'b0;
    mary_src      = SRC_ALUOUT;
    shelley_src   = SRC_ALUOUT;
    ra_src        = 1'b0;
    SrcA          = 1'b0;
    SrcB          = SRCB_MEM;
    AluOp         = 3'b000;
    trap          = 1'b0;

    case (cur_state)
      START: nxt_state = FETCH;

      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write  = 1'b1;
          pc_inc    = 1'b1;
          nxt_state = DECODE;
        end
      end

      DECODE: begin
        case (opcode)
          OP_ADDI, OP_SUBI, OP_COMP, OP_JAL, OP_BEQ: nxt_state = EXEC;
          OP_ADDM, OP_LOAD, OP_STORE:                nxt_state = MEM;
          default:                                   nxt_state = TRAP;
        endcase
      end

      EXEC: begin
        nxt_state = FETCH;
        case (opcode)
          OP_ADDI, OP_SUBI: begin
            SrcB  = SRCB_IMM;
            AluOp = (opcode == OP_SUBI) ? ALU_SUB : ALU_ADD;
            if (ovf_kill) nxt_state  = TRAP;
            else          mary_write = 1'b1;
          end
          OP_COMP: begin
            SrcB       = SRCB_SHEL;
            AluOp      = ALU_SUB;
            comp_write = 1'b1;
          end
          OP_JAL: begin
            ra_write = 1'b1;
            pc_load  = 1'b1;
          end
          OP_BEQ:  pc_load = comp_zero;
          default: ;
        endcase
      end

      MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        if (mem_ready) nxt_state = FETCH;
        case (opcode)
          OP_ADDM: begin
            SrcB  = SRCB_MEM;
            AluOp = ALU_ADD;
            if (mem_ready) begin
              if (ovf_kill) nxt_state  = TRAP;
              else          mary_write = 1'b1;
            end
          end
          OP_LOAD: begin
            shelley_src   = SRC_MEMVAL;
            shelley_write = mem_ready;
          end
          OP_STORE: mem_we = 1'b1;
          default:  ;
        endcase
      end

      TRAP: trap = 1'b1;

      default: nxt_state = START;
    endcase
  end

endmodule
